// File: rtl/mult_seq_ctrl_haleyorr2027_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the FSM state encoding, datapath widths and iteration count.
package mult_seq_ctrl_haleyorr2027_pkg;

   localparam int unsigned OP_W       = 8;
   localparam int unsigned PROD_W     = 16;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned ITER_COUNT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ADD   = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   // True on the SHIFT that completes the final iteration.
   function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
      return cnt == CNT_W'(ITER_COUNT - 1);
   endfunction

endpackage

// File: rtl/mult_seq_ctrl_haleyorr2027_if.sv
// Request/result bundle of the sequential multiplier.
// The requester drives start and operands; the multiplier returns status and product.
interface mult_seq_ctrl_haleyorr2027_if;
   import mult_seq_ctrl_haleyorr2027_pkg::*;

   logic              start;
   logic [OP_W-1:0]   multiplicand;
   logic [OP_W-1:0]   multiplier;
   logic              busy;
   logic              done;
   logic [PROD_W-1:0] product;

   modport master (
      output start,
      output multiplicand,
      output multiplier,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  multiplicand,
      input  multiplier,
      output busy,
      output done,
      output product
   );

endinterface

// File: rtl/mult_seq_ctrl_haleyorr2027_adder.sv
// 8-bit unsigned adder with carry out, used for the partial-product accumulate.
module adder_8bit_haleyorr2027
   import mult_seq_ctrl_haleyorr2027_pkg::*;
(
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   output logic            cout,
   output logic [OP_W-1:0] sum
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_seq_ctrl_haleyorr2027.sv
// Sequential 8x8 unsigned shift-add multiplier: one ADD and one SHIFT per multiplier bit.
// product is {A,Q}; valid from the done pulse until the next accepted request.
module mult_seq_ctrl_haleyorr2027
   import mult_seq_ctrl_haleyorr2027_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   mult_seq_ctrl_haleyorr2027_if.slave   bus
);

   state_t             r_state;
   state_t             w_next;

   logic [OP_W-1:0]    r_m;
   logic [OP_W-1:0]    r_a;
   logic [OP_W-1:0]    r_q;
   logic               r_c;
   logic [CNT_W-1:0]   r_cnt;

   logic [OP_W-1:0]    w_sum;
   logic               w_cout;
   logic               w_accept;
   logic               w_add_en;
   logic               w_shift_en;
   logic               w_busy;
   logic               w_done;

   adder_8bit_haleyorr2027 u_adder (
      .a    (r_a),
      .b    (r_m),
      .cout (w_cout),
      .sum  (w_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // start only matters in IDLE; DONE always returns to IDLE first.
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_add_en   = 1'b0;
      w_shift_en = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_accept = 1'b1;
               w_next   = ST_ADD;
            end
         end
         ST_ADD: begin
            w_busy   = 1'b1;
            w_add_en = 1'b1;
            w_next   = ST_SHIFT;
         end
         ST_SHIFT: begin
            w_busy     = 1'b1;
            w_shift_en = 1'b1;
            w_next     = is_last_iter(r_cnt) ? ST_DONE : ST_ADD;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m   <= '0;
         r_a   <= '0;
         r_q   <= '0;
         r_c   <= 1'b0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_m   <= bus.multiplicand;
         r_q   <= bus.multiplier;
         r_a   <= '0;
         r_c   <= 1'b0;
         r_cnt <= '0;
      end else if (w_add_en) begin
         if (r_q[0]) begin
            {r_c, r_a} <= {w_cout, w_sum};
         end else begin
            r_c <= 1'b0;
         end
      end else if (w_shift_en) begin
         // 17-bit logical right shift of {C,A,Q}; carry drops into A's MSB.
         {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[OP_W-1:1]};
         r_cnt           <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.busy    = w_busy;
   assign bus.done    = w_done;
   assign bus.product = {r_a, r_q};

endmodule

// File: doc/mult_seq_ctrl_haleyorr2027.md
MULT_SEQ_CTRL_HALEYORR2027 -- requirements
Module: mult_seq_ctrl_haleyorr2027

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 multiplicand  input  8  unsigned operand M; captured on accept.
REQ-006 multiplier  input  8  unsigned operand Q; captured on accept.
REQ-007 busy  output  1  high in ADD and SHIFT states.
REQ-008 done  output  1  single-cycle pulse, high only in DONE state.
REQ-009 product  output  16  unsigned M*Q; registered {A,Q}; stable from DONE until next accept.

Function
REQ-010 Algorithm: unsigned shift-add; registers M[7:0], A[7:0], Q[7:0], C (1 bit), cnt[3:0].
REQ-011 FSM states: IDLE, ADD, SHIFT, DONE; no other reachable state.
REQ-012 IDLE & start at edge: M<=multiplicand, Q<=multiplier, A<=0, C<=0, cnt<=0, go to ADD.
REQ-013 IDLE & !start: remain IDLE, all datapath registers hold.
REQ-014 ADD: if Q[0]=1 then {C,A}<={cout,sum} of A+M via adder sub-module, else C<=0 and A holds; go to SHIFT.
REQ-015 SHIFT: {C,A,Q}<={1'b0,C,A,Q[7:1]}, i.e. 17-bit logical right shift by one; cnt<=cnt+1.
REQ-016 SHIFT with cnt==7 (8th shift) goes to DONE; otherwise goes to ADD.
REQ-017 DONE: done=1 for exactly one cycle; unconditionally go to IDLE next edge.
REQ-018 Latency: accept edge at cycle 0, done high in cycle 17 (16 busy cycles: 8 ADD, 8 SHIFT).
REQ-019 start while busy or in DONE: ignored, no effect on operands or state.
REQ-020 start held high continuously: new accept on first IDLE cycle after DONE; minimum 18 cycles between accepts.
REQ-021 Operand inputs may change freely after accept; result depends only on captured values.
REQ-022 Carry out of adder never lost: max A+M = 510 fits in {C,A}; 255*255 = 0xFE01 exact.
REQ-023 product = {A,Q} continuously; while busy it shows intermediate values and is not valid.
REQ-024 Arithmetic unsigned throughout; no overflow possible in 16-bit product.

Reset
REQ-025 rst_n low asynchronously forces IDLE, busy=0, done=0, product=0x0000, M=0, C=0, cnt=0.
REQ-026 Reset mid-operation aborts multiply; no done pulse for aborted operation; first start after rst_n high is accepted normally.
REQ-027 Reset deassertion synchronised externally; block needs no internal reset synchroniser.

Structure
REQ-028 Shared package holds FSM state encoding constants (IDLE, ADD, SHIFT, DONE, 2-bit) and ITER_COUNT=8.
REQ-029 One sub-module: adder_8bit_haleyorr2027 instantiated once, a=A, b=M, outputs cout/sum feed ADD state.
REQ-030 FSM next-state logic and datapath registers in this module; no other sub-modules.

Verification
REQ-031 M=13, Q=11, start one cycle -> busy 16 cycles, done pulse cycle 17, product=0x008F (143).
REQ-032 M=255, Q=255 -> product=0xFE01 (65025); checks adder carry capture.
REQ-033 M=0, Q=200 and M=200, Q=0 -> product=0x0000 each; done still at cycle 17.
REQ-034 start toggled high at cycles 3 and 9 of operation with changed operands -> ignored; product of original operands.
REQ-035 start held high with M=7,Q=6 -> product 0x002A at first done; second accept at cycle 18, second done at cycle 35.
REQ-036 rst_n low at cycle 5 of 100*3 operation -> immediately busy=0, product=0, no done; then 100*3 -> 0x012C.
